// File: rtl/sonar_rx_parser.sv
// rtl/sonar_rx_parser.sv - 7O1 serial receiver and "AAA,DDD#" frame parser for sonar measurements
module sonar_rx_parser #(
  parameter int         CLKS_PER_BIT = 434,
  parameter logic [6:0] SEP_CHAR     = 7'h2C,
  parameter logic [6:0] END_CHAR     = 7'h23
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        entrada_serial,
  output logic [11:0] angulo,
  output logic [11:0] distancia,
  output logic        pronto,
  output logic        erro,
  output logic [3:0]  db_estado_rx,
  output logic [3:0]  db_estado_parser,
  output logic [6:0]  db_dado
);

  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] T_HALF = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] T_FULL = TW'(CLKS_PER_BIT - 1);

  localparam logic [3:0] S_INICIAL      = 4'd0;
  localparam logic [3:0] S_ESPERA_BORDA = 4'd1;
  localparam logic [3:0] S_START        = 4'd2;
  localparam logic [3:0] S_DADOS        = 4'd3;
  localparam logic [3:0] S_PARIDADE     = 4'd4;
  localparam logic [3:0] S_STOP         = 4'd5;
  localparam logic [3:0] S_ESPERA_ALTO  = 4'd6;

  localparam logic [3:0] P_A_C    = 4'd0;
  localparam logic [3:0] P_A_D    = 4'd1;
  localparam logic [3:0] P_A_U    = 4'd2;
  localparam logic [3:0] P_SEP    = 4'd3;
  localparam logic [3:0] P_D_C    = 4'd4;
  localparam logic [3:0] P_D_D    = 4'd5;
  localparam logic [3:0] P_D_U    = 4'd6;
  localparam logic [3:0] P_FIM    = 4'd7;
  localparam logic [3:0] P_RESYNC = 4'd8;

  logic          sync0;
  logic          rx;
  logic [3:0]    rx_state;
  logic [TW-1:0] timer;
  logic [2:0]    bit_cnt;
  logic [6:0]    shreg;
  logic          par_err;
  logic          chr_strobe;
  logic          chr_bad;

  logic [3:0]    p_state;
  logic [11:0]   ang_sh;
  logic [11:0]   dist_sh;

  logic          is_digit;
  logic          is_sep;
  logic          is_end;
  logic          accept;
  logic [3:0]    p_next;
  logic [3:0]    err_dest;

  // Two-flop synchronizer; idles high so reset never looks like a start bit
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync0 <= 1'b1;
      rx    <= 1'b1;
    end else begin
      sync0 <= entrada_serial;
      rx    <= sync0;
    end
  end

  // Receiver: mid-bit sampling of start, 7 data bits LSB first, odd parity, stop
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_state   <= S_INICIAL;
      timer      <= '0;
      bit_cnt    <= 3'd0;
      shreg      <= 7'd0;
      par_err    <= 1'b0;
      chr_strobe <= 1'b0;
      chr_bad    <= 1'b0;
    end else begin
      chr_strobe <= 1'b0;
      case (rx_state)
        S_INICIAL: rx_state <= S_ESPERA_BORDA;
        S_ESPERA_BORDA: begin
          if (!rx) begin
            rx_state <= S_START;
            timer    <= '0;
          end
        end
        S_START: begin
          if (timer == T_HALF) begin
            timer    <= '0;
            bit_cnt  <= 3'd0;
            rx_state <= rx ? S_ESPERA_BORDA : S_DADOS;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_DADOS: begin
          if (timer == T_FULL) begin
            timer   <= '0;
            shreg   <= {rx, shreg[6:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd6) rx_state <= S_PARIDADE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_PARIDADE: begin
          if (timer == T_FULL) begin
            timer    <= '0;
            par_err  <= ~(^{shreg, rx});
            rx_state <= S_STOP;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_STOP: begin
          if (timer == T_FULL) begin
            timer      <= '0;
            chr_strobe <= 1'b1;
            chr_bad    <= par_err | ~rx;
            rx_state   <= rx ? S_ESPERA_BORDA : S_ESPERA_ALTO;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_ESPERA_ALTO: if (rx) rx_state <= S_ESPERA_BORDA;
        default: rx_state <= S_INICIAL;
      endcase
    end
  end

  // Debug copy of the most recent character, good or bad
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) db_dado <= 7'd0;
    else if (chr_strobe) db_dado <= shreg;
  end

  // Character classification and the parser's next state if the character fits
  always_comb begin
    is_digit = (shreg >= 7'h30) && (shreg <= 7'h39);
    is_sep   = (shreg == SEP_CHAR);
    is_end   = (shreg == END_CHAR);
    err_dest = is_end ? P_A_C : P_RESYNC;
    accept   = 1'b0;
    p_next   = P_A_C;
    case (p_state)
      P_A_C, P_A_D, P_A_U, P_D_C, P_D_D, P_D_U: begin
        accept = is_digit;
        p_next = p_state + 4'd1;
      end
      P_SEP: begin
        accept = is_sep;
        p_next = P_D_C;
      end
      P_FIM: begin
        accept = is_end;
        p_next = P_A_C;
      end
      default: begin
        accept = 1'b0;
        p_next = P_A_C;
      end
    endcase
  end

  // Parser: fill shadows digit by digit, publish on terminator, resync on error
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      p_state   <= P_A_C;
      ang_sh    <= 12'd0;
      dist_sh   <= 12'd0;
      angulo    <= 12'd0;
      distancia <= 12'd0;
      pronto    <= 1'b0;
      erro      <= 1'b0;
    end else begin
      pronto <= 1'b0;
      erro   <= 1'b0;
      if (chr_strobe) begin
        if (p_state == P_RESYNC) begin
          if (!chr_bad && is_end) p_state <= P_A_C;
        end else if (chr_bad) begin
          erro    <= 1'b1;
          p_state <= P_RESYNC;
        end else if (accept) begin
          p_state <= p_next;
          case (p_state)
            P_A_C: ang_sh[11:8]  <= shreg[3:0];
            P_A_D: ang_sh[7:4]   <= shreg[3:0];
            P_A_U: ang_sh[3:0]   <= shreg[3:0];
            P_D_C: dist_sh[11:8] <= shreg[3:0];
            P_D_D: dist_sh[7:4]  <= shreg[3:0];
            P_D_U: dist_sh[3:0]  <= shreg[3:0];
            P_FIM: begin
              angulo    <= ang_sh;
              distancia <= dist_sh;
              pronto    <= 1'b1;
            end
            default: ;
          endcase
        end else begin
          erro    <= 1'b1;
          p_state <= err_dest;
        end
      end
    end
  end

  assign db_estado_rx     = rx_state;
  assign db_estado_parser = p_state;

endmodule

// File: doc/sonar_rx_parser.md
Name: sonar_rx_parser

Overview:
- Receives the sonar's 7O1 serial stream and rebuilds each measurement frame.
- Frame format: 3 angle digits, separator, 3 distance digits, terminator.
- On each well-formed frame, publishes the angle and distance as 12-bit BCD, with a one-cycle `pronto` pulse.
- Sits directly downstream of the sonar datapath's serial output, either on the receiving board or in loopback test logic.
- Malformed frames are dropped. The last good values are held.

Parameters:
- `CLKS_PER_BIT`, 434, clock cycles per serial bit (50 MHz / 115200 baud).
- `SEP_CHAR`, 7'h2C, ASCII separator between angle and distance (',').
- `END_CHAR`, 7'h23, ASCII frame terminator ('#').

Ports:
- `clock`  input  1  system clock, rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `entrada_serial`  input  1  asynchronous serial line, idle high.
- `angulo`  output  12  last good angle, BCD {centena, dezena, unidade}.
- `distancia`  output  12  last good distance, BCD {centena, dezena, unidade}.
- `pronto`  output  1  one-cycle pulse: `angulo`/`distancia` updated.
- `erro`  output  1  one-cycle pulse: current frame discarded.
- `db_estado_rx`  output  4  receiver FSM state code.
- `db_estado_parser`  output  4  parser FSM state code.
- `db_dado`  output  7  last received character.

Behaviour:

Reset and input sync:
- `reset`=0 asynchronously clears all state.
- Reset values:
  - `angulo`=0, `distancia`=0, `pronto`=0, `erro`=0, `db_dado`=0.
  - Both FSMs return to their first state (code 0).
  - Synchronizer flops are set to 1.
- `entrada_serial` passes through a 2-flop synchronizer (set to 1 on reset). All logic uses the synced bit `rx`.

Receiver FSM:
- States and codes: INICIAL=0, ESPERA_BORDA=1, START=2, DADOS=3, PARIDADE=4, STOP=5, ESPERA_ALTO=6.
- INICIAL -> ESPERA_BORDA after one cycle.
- ESPERA_BORDA: `rx`=0 -> START, clear bit timer.
- START:
  - At timer = `CLKS_PER_BIT`/2 - 1, resample `rx`.
  - `rx`=1: glitch -> ESPERA_BORDA, no character.
  - `rx`=0: -> DADOS, timer cleared.
- DADOS:
  - Sample at each timer = `CLKS_PER_BIT` - 1 (mid-bit), then clear timer.
  - 7 data bits, LSB first, shifted into a 7-bit register.
  - After the 7th bit -> PARIDADE.
- PARIDADE:
  - Sample one bit.
  - Parity error when XOR of the 7 data bits and the parity bit = 0 (odd parity required).
- STOP:
  - Sample one bit.
  - Next cycle: issue an internal one-cycle character strobe with flag `bad` = parity error OR stop bit = 0.
  - `db_dado` loads the character on that strobe.
  - Stop = 1 -> ESPERA_BORDA; stop = 0 -> ESPERA_ALTO.
- ESPERA_ALTO: wait for `rx`=1, then -> ESPERA_BORDA.
- Bit timer width: ceil(log2(`CLKS_PER_BIT`)).
- Back-to-back characters with one stop bit must be received without loss.

Parser FSM (advances only on a character strobe):
- States and codes: A_C=0, A_D=1, A_U=2, SEP=3, D_C=4, D_D=5, D_U=6, FIM=7, RESYNC=8.
- Digit = 7'h30..7'h39. Its low nibble is stored in a shadow register:
  - A_C, A_D, A_U fill the angle shadow (centena, dezena, unidade).
  - D_C, D_D, D_U fill the distance shadow.
- Advance order: A_C -> A_D -> A_U -> SEP -> D_C -> D_D -> D_U -> FIM.
- SEP accepts only `SEP_CHAR`. FIM accepts only `END_CHAR`.
- Valid char in FIM:
  - Next cycle: copy shadows to `angulo`/`distancia` and pulse `pronto`.
  - Parser -> A_C.
- Any error goes to RESYNC and pulses `erro` for one cycle, in the cycle after the strobe. Errors are:
  - `bad` strobe;
  - unexpected character;
  - `END_CHAR` arriving before FIM.
- RESYNC:
  - Discard characters until `END_CHAR` (with `bad`=0), then -> A_C.
  - No `pronto`, no further `erro`.
- Exception: an error caused by `END_CHAR` itself goes directly to A_C, not RESYNC.
- Outputs:
  - `angulo`/`distancia` change only on `pronto`.
  - `pronto` and `erro` are never high together.
- Reset mid-frame: shadows and outputs are cleared, and the parser restarts at A_C. The partial frame is lost.

Test Plan:
- Send "045,123#" (correct odd parity, `CLKS_PER_BIT`=434) -> one `pronto` pulse; `angulo`=12'h045, `distancia`=12'h123; `erro` never high.
- Send "090,007#" immediately followed by "180,250#", back-to-back -> two `pronto` pulses; final `angulo`=12'h180, `distancia`=12'h250.
- Send "045,1X3#" after a good "020,030#" -> `erro` pulses once on 'X'; no `pronto`; outputs stay 12'h020/12'h030. A following "100,200#" -> `pronto`, 12'h100/12'h200.
- Flip the parity bit of '2' in "012,345#" -> `erro` pulse, frame dropped, outputs unchanged. The next good frame is accepted.
- Drive a 100-cycle low glitch in idle -> receiver returns to ESPERA_BORDA; no strobe, `pronto`=0, `erro`=0. A stop bit forced low -> `erro` pulse; `db_estado_rx`=6 until the line returns high.
- Assert `reset`=0 mid-frame after "12" -> `angulo`=0, `distancia`=0, FSM states 0. A full "030,040#" afterwards -> `pronto` with 12'h030/12'h040.
